// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// The optional watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT_CYC = 16;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant.
// Search order is last_grant+1, last_grant+2, ... wrapping modulo NUM_REQ.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [GW-1:0]      last_grant,
    output logic               found,
    output logic [GW-1:0]      index
);

    int cand;

    // Walk from the farthest offset to the nearest so the nearest valid one wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = int'(last_grant) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req_valid[cand]) begin
                found = 1'b1;
                index = cand[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to add a watchdog on tx_busy rising after a launch.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int GW          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [GW-1:0]        grant_id,
    output logic                 active,
    output logic                 err_timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYC must be at least 1");
    end

    arb_state_t           state_reg, state_next;
    logic [GW-1:0]        last_grant_reg, last_grant_next;
    logic [GW-1:0]        grant_id_reg, grant_id_next;
    logic [7:0]           tx_data_reg, tx_data_next;
    logic                 tx_start_reg, tx_start_next;
    logic [NUM_REQ-1:0]   req_ready_reg, req_ready_next;
    logic                 pick_found;
    logic [GW-1:0]        pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [7:0]           pick_byte [NUM_REQ];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]      wd_cnt_reg, wd_cnt_next;
    logic                 err_reg, err_next;
`endif

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant_reg),
        .found      (pick_found),
        .index      (pick_idx)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
        assign pick_onehot[gi] = (pick_idx == GW'(gi));
        assign pick_byte[gi]   = req_data[8*gi +: 8];
    end

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_id_next   = grant_id_reg;
        tx_data_next    = tx_data_reg;
        tx_start_next   = 1'b0;
        req_ready_next  = '0;
`ifdef UART_ARB_TIMEOUT_EN
        wd_cnt_next     = '0;
        err_next        = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (!tx_busy && pick_found) begin
                    state_next      = LAUNCH;
                    last_grant_next = pick_idx;
                    grant_id_next   = pick_idx;
                    tx_data_next    = pick_byte[pick_idx];
                    tx_start_next   = 1'b1;
                    req_ready_next  = pick_onehot;
                end
            end
            LAUNCH: begin
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                // last_grant already points at the aborted requester, so it waits its turn.
                else if (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    wd_cnt_next = wd_cnt_reg + 1'b1;
                end
`endif
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= GW'(NUM_REQ - 1);
            grant_id_reg   <= '0;
            tx_data_reg    <= 8'h00;
            tx_start_reg   <= 1'b0;
            req_ready_reg  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt_reg     <= '0;
            err_reg        <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            grant_id_reg   <= grant_id_next;
            tx_data_reg    <= tx_data_next;
            tx_start_reg   <= tx_start_next;
            req_ready_reg  <= req_ready_next;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt_reg     <= wd_cnt_next;
            err_reg        <= err_next;
`endif
        end
    end

    assign req_ready = req_ready_reg;
    assign tx_start  = tx_start_reg;
    assign tx_data   = tx_data_reg;
    assign grant_id  = grant_id_reg;
    assign active    = (state_reg != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    assign err_timeout = err_reg;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus pushes expected grants,
// a negedge monitor pops and checks each tx_start; UART busy comes from a small model.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int GW      = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ*8-1:0] req_data = {8'hC3, 8'hA5, 8'h7E, 8'h19};
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_start;
    wire                  tx_busy;
    logic [GW-1:0]        grant_id;
    logic                 active;
    logic                 err_timeout;

    logic force_busy = 1'b0;
    logic model_busy = 1'b0;
    logic model_en   = 1'b0;
    assign tx_busy = force_busy | model_busy;

    typedef struct packed {
        logic [GW-1:0] gid;
        logic [7:0]    data;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push(input int gid);
        exp_t e;
        e.gid  = GW'(gid);
        e.data = req_data[8*gid +: 8];
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (tx_start) seen = 1'b1;
        end
        chk({name, "_start_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit idle = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            step();
            if (!active) idle = 1'b1;
        end
        chk({name, "_idle_seen"}, 32'(idle), 32'd1);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({name, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({name, "_tx_data"}, 32'(tx_data), 32'h00);
        chk({name, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({name, "_active"}, 32'(active), 32'd0);
        chk({name, "_err"}, 32'(err_timeout), 32'd0);
    endtask

    // UART model: busy for 10 cycles starting just after each tx_start.
    initial begin
        forever begin
            step();
            if (model_en && tx_start) begin
                model_busy = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                model_busy = 1'b0;
            end
        end
    end

    // Monitor: every tx_start must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_start", 32'(grant_id), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn grant=%0d data=%02h ready=%b", grant_id, tx_data, req_ready);
                    chk("sb_grant_id", 32'(grant_id), 32'(e.gid));
                    chk("sb_tx_data", 32'(tx_data), 32'(e.data));
                    chk("sb_req_ready", 32'(req_ready), 32'(4'b0001 << e.gid));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) step();
        chk_reset_vals("reset");

        // Single request on slot 2, launched one cycle after it is sampled.
        rst = 1'b0;
        req_valid = 4'b0100;
        push(2);
        step();
        chk("single_latency", 32'(tx_start), 32'd1);
        chk("single_active", 32'(active), 32'd1);
        req_valid = '0;
        step();
        force_busy = 1'b1;
        repeat (3) step();
        force_busy = 1'b0;
        wait_idle("single");

        // Contention after reset: order 0,1,2,3,0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_en = 1'b1;
        push(0); push(1); push(2); push(3); push(0);
        req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) wait_start("contend");
        req_valid = '0;
        wait_idle("contend");

        // Busy blocking: no launch while tx_busy is held high.
        force_busy = 1'b1;
        req_valid = 4'b0001;
        push(0);
        for (int n = 0; n < 5; n++) begin
            step();
            chk("block_no_start", 32'(tx_start), 32'd0);
        end
        force_busy = 1'b0;
        step();
        chk("block_release_start", 32'(tx_start), 32'd1);
        req_valid = '0;
        wait_idle("block");

        // Reset during WAIT_DONE aborts to reset values.
        req_valid = 4'b0010;
        push(1);
        wait_start("midrst");
        req_valid = '0;
        repeat (3) step();
        chk("midrst_busy_active", 32'(active), 32'd1);
        rst = 1'b1;
        step();
        chk_reset_vals("midrst");
        rst = 1'b0;
        repeat (12) step();
        chk("midrst_stays_idle", 32'(active), 32'd0);

        // Watchdog: tx_busy never rises after the launch.
        model_en = 1'b0;
        req_valid = 4'b0001;
        push(0);
        wait_start("wdog");
        req_valid = '0;
        step();
`ifdef UART_ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k < 16) begin
                chk("wdog_err_low", 32'(err_timeout), 32'd0);
            end else begin
                chk("wdog_err_pulse", 32'(err_timeout), 32'd1);
                chk("wdog_idle", 32'(active), 32'd0);
            end
        end
        step();
        chk("wdog_err_one_cycle", 32'(err_timeout), 32'd0);
`else
        for (int k = 1; k <= 30; k++) begin
            step();
            chk("nowdog_err_low", 32'(err_timeout), 32'd0);
        end
        chk("nowdog_still_waiting", 32'(active), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
`endif

        step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing one UART transmitter; legal range is 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 16, is the watchdog limit in clk cycles for tx_busy to rise after a launch.
REQ-003 clk  input  1  single system clock; all logic is clocked on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  bit i high means requester i holds a byte to send.
REQ-006 req_data  input  NUM_REQ*8  byte of requester i is on bits [8i+7:8i].
REQ-007 req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester.
REQ-008 tx_data  output  8  byte presented to the UART transmitter data input.
REQ-009 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 tx_busy  input  1  busy flag from the UART transmitter.
REQ-011 grant_id  output  clog2(NUM_REQ)  index of the current or last granted requester.
REQ-012 active  output  1  high whenever state is not IDLE.
REQ-013 err_timeout  output  1  one-cycle pulse when the watchdog fires.

Function
REQ-014 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
- IDLE -> LAUNCH: at a clock edge where tx_busy=0 and any req_valid=1.
- LAUNCH -> WAIT_BUSY: unconditionally, after one cycle.
- WAIT_BUSY -> WAIT_DONE: when tx_busy=1.
- WAIT_DONE -> IDLE: when tx_busy=0.
REQ-015 IDLE SHALL NOT grant while tx_busy=1, even if requests are pending.
REQ-016 Arbitration SHALL be round-robin. The search starts at (last_grant+1) mod NUM_REQ and selects the first requester with req_valid=1.
REQ-017 On the IDLE->LAUNCH edge, the block SHALL register the selected byte into tx_data and the selected index into grant_id, and update last_grant.
REQ-018 In the LAUNCH cycle, tx_start=1 and req_ready[grant_id]=1. Both are 0 in every other cycle.
REQ-019 Latency SHALL be exactly one cycle from the edge that samples req_valid to the tx_start/req_ready pulse.
REQ-020 A requester SHALL hold req_valid and req_data stable until its req_ready pulse. If it drops req_valid before being granted, it is simply not served.
REQ-021 tx_data SHALL hold its value from LAUNCH until the next grant.
REQ-022 Requests arriving in any non-IDLE state SHALL wait. Arbitration happens only in IDLE.
REQ-023 If all NUM_REQ requesters are valid continuously, grants SHALL rotate 0,1,...,NUM_REQ-1,0 with no requester granted twice before every other requester is granted once.
REQ-024 err_timeout SHALL be 0 whenever UART_ARB_TIMEOUT_EN is undefined.

Reset
REQ-025 While rst=1, the block SHALL force: state=IDLE, tx_start=0, req_ready=0, tx_data=8'h00, grant_id=0, last_grant=NUM_REQ-1 (so requester 0 has first priority), active=0, err_timeout=0, watchdog counter=0.
REQ-026 Reset asserted mid-transfer SHALL abort immediately to the reset values; no pending request is retained.

Configuration
REQ-027 With macro UART_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_BUSY. If tx_busy has not risen after TIMEOUT_CYC cycles, the FSM returns to IDLE and err_timeout pulses for one cycle. The aborted requester is not re-granted ahead of its round-robin turn.
REQ-028 With UART_ARB_TIMEOUT_EN undefined, there SHALL be no watchdog counter, and WAIT_BUSY waits indefinitely for tx_busy.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state enum and the default TIMEOUT_CYC constant.
REQ-030 The round-robin selection SHALL be a combinational sub-module, uart_rr_pick, with inputs req_valid and last_grant and outputs found and index.

Verification
REQ-031 Single request: after reset, req_valid=4'b0100 with byte 8'hA5 on slot 2. Next cycle: tx_start=1, req_ready=4'b0100, tx_data=8'hA5, grant_id=2.
REQ-032 Contention: req_valid=4'b1111 held, with the model asserting tx_busy for 10 cycles per byte. Required grant order: 0,1,2,3,0 and exactly one tx_start per byte.
REQ-033 Busy blocking: tx_busy=1 held externally while req_valid=4'b0001. Required: no tx_start until tx_busy=0, then a grant one cycle later.
REQ-034 Reset mid-transfer: rst=1 during WAIT_DONE. Next cycle: all outputs at reset values and active=0.
REQ-035 Watchdog (UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16): tx_busy held 0 after launch. Required: err_timeout pulses 16 cycles after entering WAIT_BUSY, then the FSM is in IDLE.
REQ-036 Watchdog absent (UART_ARB_TIMEOUT_EN undefined), same stimulus as REQ-035: the FSM stays in WAIT_BUSY and err_timeout stays 0.
